// File: rtl/sr_mc_pkg.sv
// Shared encodings for the multicycle sequencer and the core control decoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sr_mc_pkg;

    // Sequencer states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_START = 2'd1,
        MC_WAIT  = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_e;

    // Unit indices as wired into the unit_start/unit_busy/unit_result buses.
    localparam int MC_UNIT_MUL = 0;
    localparam int MC_UNIT_DIV = 1;
    localparam int MC_UNIT_FN0 = 2;
    localparam int MC_UNIT_FN1 = 3;

    // Register-file address width of the core.
    localparam int MC_RD_W = 5;

endpackage

// File: rtl/sr_mc_watchdog.sv
// Busy watchdog: counts enabled cycles, flags when the count reaches all-ones.
// Latency: expire is a decode of the registered count, valid the cycle the count lands.
// Backpressure: none; clr has priority over en, count wraps if left enabled.
module sr_mc_watchdog
    import sr_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    // Count consecutive busy cycles; restarted at each unit start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // All-ones means this is the 2^W-th busy cycle since the clear.
    assign expire = &cnt;

endmodule

// File: rtl/sr_mc_sequencer.sv
// Multicycle sequencer: stalls the PC, starts one extension unit, waits, writes back.
// Latency: 3+L cycles from mc_req in IDLE to DONE for a unit busy L cycles.
// Backpressure: holds pc_en low while the selected unit is busy, bounded by the watchdog.
module sr_mc_sequencer
    import sr_mc_pkg::*;
#(
    parameter int N_UNITS    = 4,
    parameter int DATA_W     = 32,
    parameter int UNIT_W     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
    parameter int TIMEOUT_EN = 1,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mc_req,
    input  logic [UNIT_W-1:0]           mc_unit,
    input  logic [MC_RD_W-1:0]          mc_rd,
    output logic [N_UNITS-1:0]          unit_start,
    input  logic [N_UNITS-1:0]          unit_busy,
    input  logic [N_UNITS*DATA_W-1:0]   unit_result,
    output logic                        pc_en,
    output logic                        wb_we,
    output logic [MC_RD_W-1:0]          wb_addr,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        err,
    input  logic                        err_clr,
    output logic [1:0]                  state_o
);

    // One extra bit so the legality compare also works when N_UNITS is a power of two.
    localparam logic [UNIT_W:0] N_UNITS_V = (UNIT_W + 1)'(N_UNITS);

    mc_state_e             state;
    mc_state_e             stateNext;
    logic [UNIT_W-1:0]     selUnit;
    logic [MC_RD_W-1:0]    selRd;
    logic                  selBusy;
    logic [DATA_W-1:0]     selResult;
    logic                  unitLegal;
    logic                  wdExpire;
    logic                  wdClr;
    logic                  wdEn;
    logic                  timeoutHit;
    logic                  illegalHit;
    logic                  captureHit;

    assign unitLegal  = ({1'b0, mc_unit} < N_UNITS_V);
    assign wdClr      = (state == MC_START);
    assign wdEn       = (state == MC_WAIT) && selBusy;
    assign timeoutHit = (TIMEOUT_EN != 0) && (state == MC_WAIT) && selBusy && wdExpire;
    assign illegalHit = (state == MC_IDLE) && mc_req && !unitLegal;
    assign captureHit = (state == MC_WAIT) && !selBusy;
    assign state_o    = state;

    sr_mc_watchdog #(
        .W      (TIMEOUT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdClr),
        .en     (wdEn),
        .expire (wdExpire)
    );

    // Select busy/result of the captured unit; other units are don't-care.
    always_comb begin
        selBusy   = 1'b0;
        selResult = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (selUnit == UNIT_W'(k)) begin
                selBusy   = unit_busy[k];
                selResult = unit_result[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, PC enable and the one-cycle start pulse.
    always_comb begin
        stateNext  = state;
        pc_en      = 1'b0;
        unit_start = '0;
        case (state)
            MC_IDLE: begin
                pc_en = !mc_req;
                if (mc_req) begin
                    stateNext = unitLegal ? MC_START : MC_DONE;
                end
            end
            MC_START: begin
                for (int k = 0; k < N_UNITS; k++) begin
                    unit_start[k] = (selUnit == UNIT_W'(k));
                end
                stateNext = MC_WAIT;
            end
            MC_WAIT: begin
                if (!selBusy || timeoutHit) begin
                    stateNext = MC_DONE;
                end
            end
            MC_DONE: begin
                pc_en     = 1'b1;
                stateNext = MC_IDLE;
            end
            default: begin
                stateNext = MC_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MC_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Latch unit and destination once; later decoder changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selUnit <= '0;
            selRd   <= '0;
        end else if ((state == MC_IDLE) && mc_req && unitLegal) begin
            selUnit <= mc_unit;
            selRd   <= mc_rd;
        end
    end

    // Registered writeback: loaded when the unit drops busy, write enable lasts one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (captureHit) begin
            wb_we   <= (selRd != '0);
            wb_addr <= selRd;
            wb_data <= selResult;
        end else if (timeoutHit || (state == MC_DONE)) begin
            wb_we   <= 1'b0;
        end
    end

    // Sticky error; a new error in the same cycle as err_clr keeps err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (illegalHit || timeoutHit) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_mc_sequencer.sv
// Bench for sr_mc_sequencer: cycle table for normal operation, hand sequences for corners.
// Latency: not applicable.
// Backpressure: unit busy is driven directly from the vectors.
module tb_sr_mc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: four units, short watchdog.
    logic         aReq;
    logic [1:0]   aUnit;
    logic [4:0]   aRd;
    logic [3:0]   aStart;
    logic [3:0]   aBusy;
    logic [127:0] aResult;
    logic         aPc;
    logic         aWe;
    logic [4:0]   aAddr;
    logic [31:0]  aData;
    logic         aErr;
    logic         aClr;
    logic [1:0]   aState;

    // Instance B: three units, so index 3 is illegal.
    logic         bReq;
    logic [1:0]   bUnit;
    logic [4:0]   bRd;
    logic [2:0]   bStart;
    logic [2:0]   bBusy;
    logic [95:0]  bResult;
    logic         bPc;
    logic         bWe;
    logic [4:0]   bAddr;
    logic [31:0]  bData;
    logic         bErr;
    logic         bClr;
    logic [1:0]   bState;

    sr_mc_sequencer #(
        .N_UNITS(4), .DATA_W(32), .TIMEOUT_EN(1), .TIMEOUT_W(4)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .mc_req(aReq), .mc_unit(aUnit), .mc_rd(aRd),
        .unit_start(aStart), .unit_busy(aBusy), .unit_result(aResult),
        .pc_en(aPc), .wb_we(aWe), .wb_addr(aAddr), .wb_data(aData),
        .err(aErr), .err_clr(aClr), .state_o(aState)
    );

    sr_mc_sequencer #(
        .N_UNITS(3), .DATA_W(32), .TIMEOUT_EN(1), .TIMEOUT_W(4)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .mc_req(bReq), .mc_unit(bUnit), .mc_rd(bRd),
        .unit_start(bStart), .unit_busy(bBusy), .unit_result(bResult),
        .pc_en(bPc), .wb_we(bWe), .wb_addr(bAddr), .wb_data(bData),
        .err(bErr), .err_clr(bClr), .state_o(bState)
    );

    typedef struct {
        logic        req;
        logic [1:0]  unit;
        logic [4:0]  rd;
        logic [1:0]  tgt;
        logic [3:0]  busy;
        logic [31:0] res;
        logic [3:0]  eStart;
        logic        ePc;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eErr;
        logic [1:0]  eSt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic [1:0] unit, input logic [4:0] rd,
                                input logic [1:0] tgt, input logic [3:0] busy, input logic [31:0] res,
                                input logic [3:0] eStart, input logic ePc, input logic eWe,
                                input logic [4:0] eAddr, input logic [31:0] eData,
                                input logic eErr, input logic [1:0] eSt);
        vec_t v;
        v.req = req; v.unit = unit; v.rd = rd; v.tgt = tgt; v.busy = busy; v.res = res;
        v.eStart = eStart; v.ePc = ePc; v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
        v.eErr = eErr; v.eSt = eSt;
        return v;
    endfunction

    // Target slot carries the result, the others carry distinct junk.
    task automatic driveResultA(input logic [1:0] tgt, input logic [31:0] res);
        for (int k = 0; k < 4; k++) begin
            aResult[k*32 +: 32] = (k == int'(tgt)) ? res : (32'hDEAD_0000 | 32'(k));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset line, then unit 2 busy 3 cycles (rd 5, 0x1234) with input churn after capture.
        vecs[0]  = mk(0, 0, 0, 0, 4'b0000, 32'h0,    4'b0000, 1, 0, 0, 32'h0,    0, 0);
        vecs[1]  = mk(1, 2, 5, 2, 4'b0000, 32'h1234, 4'b0000, 0, 0, 0, 32'h0,    0, 0);
        vecs[2]  = mk(1, 2, 5, 2, 4'b0000, 32'h1234, 4'b0100, 0, 0, 0, 32'h0,    0, 1);
        vecs[3]  = mk(1, 1, 9, 2, 4'b0100, 32'h1234, 4'b0000, 0, 0, 0, 32'h0,    0, 2);
        vecs[4]  = mk(1, 1, 9, 2, 4'b0110, 32'h1234, 4'b0000, 0, 0, 0, 32'h0,    0, 2);
        vecs[5]  = mk(1, 2, 5, 2, 4'b0100, 32'h1234, 4'b0000, 0, 0, 0, 32'h0,    0, 2);
        vecs[6]  = mk(1, 2, 5, 2, 4'b0001, 32'h1234, 4'b0000, 0, 0, 0, 32'h0,    0, 2);
        vecs[7]  = mk(1, 2, 5, 2, 4'b0000, 32'h1234, 4'b0000, 1, 1, 5, 32'h1234, 0, 3);
        vecs[8]  = mk(0, 0, 0, 2, 4'b0000, 32'h1234, 4'b0000, 1, 0, 5, 32'h1234, 0, 0);
        // Zero-latency unit 0 (rd 3, 0xA5).
        vecs[9]  = mk(1, 0, 3, 0, 4'b0000, 32'hA5,   4'b0000, 0, 0, 5, 32'h1234, 0, 0);
        vecs[10] = mk(1, 0, 3, 0, 4'b0000, 32'hA5,   4'b0001, 0, 0, 5, 32'h1234, 0, 1);
        vecs[11] = mk(1, 0, 3, 0, 4'b0000, 32'hA5,   4'b0000, 0, 0, 5, 32'h1234, 0, 2);
        vecs[12] = mk(1, 0, 3, 0, 4'b0000, 32'hA5,   4'b0000, 1, 1, 3, 32'hA5,   0, 3);
        // Back-to-back: unit 3, rd 0, 2 busy cycles, result discarded.
        vecs[13] = mk(1, 3, 0, 3, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 3, 32'hA5, 0, 0);
        vecs[14] = mk(1, 3, 0, 3, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 0, 0, 3, 32'hA5, 0, 1);
        vecs[15] = mk(1, 3, 0, 3, 4'b1000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 3, 32'hA5, 0, 2);
        vecs[16] = mk(1, 3, 0, 3, 4'b1000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 3, 32'hA5, 0, 2);
        vecs[17] = mk(1, 3, 0, 3, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 0, 0, 3, 32'hA5, 0, 2);
        vecs[18] = mk(1, 3, 0, 3, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 1, 0, 0, 32'hFFFF_FFFF, 0, 3);
        vecs[19] = mk(0, 0, 0, 3, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);

        rst_n = 1'b0;
        aReq = 0; aUnit = 0; aRd = 0; aBusy = 0; aResult = '0; aClr = 0;
        bReq = 0; bUnit = 0; bRd = 0; bBusy = 0; bResult = '0; bClr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(aState), 0);
        check("rst_start", 32'(aStart), 0);
        check("rst_err",   32'(aErr),   0);
        #2 rst_n = 1'b1;

        // Table-driven cycles on instance A.
        for (int i = 0; i < NVEC; i++) begin
            tick();
            aReq = vecs[i].req; aUnit = vecs[i].unit; aRd = vecs[i].rd; aBusy = vecs[i].busy;
            driveResultA(vecs[i].tgt, vecs[i].res);
            @(negedge clk);
            check($sformatf("v%0d.start", i), 32'(aStart), 32'(vecs[i].eStart));
            check($sformatf("v%0d.pc_en", i), 32'(aPc),    32'(vecs[i].ePc));
            check($sformatf("v%0d.wb_we", i), 32'(aWe),    32'(vecs[i].eWe));
            check($sformatf("v%0d.wb_addr", i), 32'(aAddr), 32'(vecs[i].eAddr));
            check($sformatf("v%0d.wb_data", i), aData,      vecs[i].eData);
            check($sformatf("v%0d.err", i),   32'(aErr),   32'(vecs[i].eErr));
            check($sformatf("v%0d.state", i), 32'(aState), 32'(vecs[i].eSt));
        end

        // Timeout: unit 1 stuck busy, abort after the 16th busy WAIT cycle.
        tick(); aReq = 1; aUnit = 1; aRd = 7; aBusy = 0; driveResultA(1, 32'h77);
        @(negedge clk); check("to.c0_state", 32'(aState), 0);
        tick();
        @(negedge clk); check("to.c1_start", 32'(aStart), 32'h2);
        for (int c = 2; c <= 17; c++) begin
            tick(); aBusy = 4'b0010;
            @(negedge clk);
        end
        check("to.c17_state", 32'(aState), 2);
        check("to.c17_err",   32'(aErr),   0);
        tick();
        @(negedge clk);
        check("to.c18_state", 32'(aState), 3);
        check("to.c18_pc",    32'(aPc),    1);
        check("to.c18_we",    32'(aWe),    0);
        check("to.c18_err",   32'(aErr),   1);
        check("to.c18_data",  aData,       32'hFFFF_FFFF);
        tick(); aReq = 0; aBusy = 0;
        @(negedge clk);
        check("to.idle_state", 32'(aState), 0);
        repeat (2) begin tick(); @(negedge clk); end
        check("to.err_sticky", 32'(aErr), 1);
        tick(); aClr = 1;
        @(negedge clk); check("to.err_clr_cycle", 32'(aErr), 1);
        tick(); aClr = 0;
        @(negedge clk); check("to.err_cleared", 32'(aErr), 0);

        // Illegal unit on instance B, with err_clr in the same cycle.
        tick(); bReq = 1; bUnit = 3; bRd = 4; bClr = 1;
        @(negedge clk);
        check("ill.c0_start", 32'(bStart), 0);
        check("ill.c0_pc",    32'(bPc),    0);
        tick(); bClr = 0;
        @(negedge clk);
        check("ill.c1_state", 32'(bState), 3);
        check("ill.c1_pc",    32'(bPc),    1);
        check("ill.c1_we",    32'(bWe),    0);
        check("ill.c1_err",   32'(bErr),   1);
        check("ill.c1_start", 32'(bStart), 0);
        tick(); bReq = 0;
        @(negedge clk);
        check("ill.c2_state", 32'(bState), 0);
        check("ill.c2_err",   32'(bErr),   1);
        check("ill.c2_start", 32'(bStart), 0);

        // Reset in WAIT aborts; after release a held request starts next cycle.
        tick(); aReq = 1; aUnit = 2; aRd = 6; aBusy = 0; driveResultA(2, 32'h6666);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick(); aBusy = 4'b0100;
        @(negedge clk); check("rst.wait_state", 32'(aState), 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst.mid_state", 32'(aState), 0);
        check("rst.mid_we",    32'(aWe),    0);
        check("rst.mid_start", 32'(aStart), 0);
        check("rst.mid_err",   32'(aErr),   0);
        check("rst.mid_data",  aData,       0);
        tick(); rst_n = 1'b1; aBusy = 0;
        @(negedge clk); check("rst.rel_state", 32'(aState), 0);
        tick();
        @(negedge clk);
        check("rst.start_state", 32'(aState), 1);
        check("rst.start_pulse", 32'(aStart), 32'h4);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rst.done_we",   32'(aWe),   1);
        check("rst.done_addr", 32'(aAddr), 6);
        check("rst.done_data", aData,      32'h6666);
        tick(); aReq = 0;
        @(negedge clk); check("rst.after_we", 32'(aWe), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
